// File: rtl/next_state_unit.sv
// next_state_unit: control-unit sequencer. Walks the fetch path, decodes the
// instruction class into a routine start state, steps through each routine,
// and watches memory wait states for a moc timeout.
module next_state_unit #(
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        cond_true,
    input  logic        moc,
    output logic [6:0]  state,
    output logic        instr_done,
    output logic        und_trap,
    output logic        bus_err
);

    // State numbers are visible on the state output, so they stay fixed constants.
    localparam logic [6:0] S_RESET    = 7'd0;
    localparam logic [6:0] S_MAR      = 7'd1;
    localparam logic [6:0] S_PCINC    = 7'd2;
    localparam logic [6:0] S_FWAIT    = 7'd3;
    localparam logic [6:0] S_DECODE   = 7'd4;
    localparam logic [6:0] S_DP_IMM   = 7'd10;
    localparam logic [6:0] S_DP_REG   = 7'd11;
    localparam logic [6:0] S_B        = 7'd20;
    localparam logic [6:0] S_BL       = 7'd21;
    localparam logic [6:0] S_BL_LINK  = 7'd22;
    localparam logic [6:0] S_LDR_ADDR = 7'd30;
    localparam logic [6:0] S_LDR_MAR  = 7'd31;
    localparam logic [6:0] S_LDR_WAIT = 7'd32;
    localparam logic [6:0] S_LDR_WB   = 7'd33;
    localparam logic [6:0] S_STR_ADDR = 7'd40;
    localparam logic [6:0] S_STR_MAR  = 7'd41;
    localparam logic [6:0] S_STR_WAIT = 7'd42;
    localparam logic [6:0] S_BUS_ERR  = 7'd126;
    localparam logic [6:0] S_UNDEF    = 7'd127;

    localparam logic [5:0] TIMEOUT_CNT = 6'(MOC_TIMEOUT - 1);

    logic [6:0] state_q, state_d;
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic       instr_done_q, instr_done_d;
    logic       und_trap_q, und_trap_d;
    logic       bus_err_q, bus_err_d;

    logic [6:0] enc_state;
    logic       in_wait;
    logic       timeout;

    // Only the opcode-class bits take part in decoding.
    logic unused_ir;
    assign unused_ir = ^{ir[31:28], ir[23:21], ir[19:5], ir[3:0]};

    // Instruction-class encoder: routine start state for the decoded ir.
    always_comb begin
        enc_state = S_UNDEF;
        case (ir[27:25])
            3'b001: enc_state = S_DP_IMM;
            3'b000: enc_state = ir[4] ? S_UNDEF : S_DP_REG;
            3'b101: enc_state = ir[24] ? S_BL : S_B;
            3'b010: enc_state = ir[20] ? S_LDR_ADDR : S_STR_ADDR;
            default: enc_state = S_UNDEF;
        endcase
    end

    // Next-state, wait-counter and pulse computation.
    always_comb begin
        state_d      = S_RESET;
        instr_done_d = 1'b0;
        in_wait      = (state_q == S_FWAIT) || (state_q == S_LDR_WAIT) ||
                       (state_q == S_STR_WAIT);
        timeout      = (wait_cnt_q == TIMEOUT_CNT);

        case (state_q)
            S_RESET:  state_d = S_MAR;
            S_MAR:    state_d = S_PCINC;
            S_PCINC:  state_d = S_FWAIT;
            S_FWAIT: begin
                if (moc)          state_d = S_DECODE;
                else if (timeout) state_d = S_BUS_ERR;
                else              state_d = S_FWAIT;
            end
            S_DECODE: begin
                if (cond_true) begin
                    state_d = enc_state;
                end else begin
                    state_d      = S_MAR;
                    instr_done_d = 1'b1;
                end
            end
            S_DP_IMM, S_DP_REG, S_B, S_BL_LINK, S_LDR_WB, S_BUS_ERR, S_UNDEF: begin
                state_d      = S_MAR;
                instr_done_d = 1'b1;
            end
            S_BL:       state_d = S_BL_LINK;
            S_LDR_ADDR: state_d = S_LDR_MAR;
            S_LDR_MAR:  state_d = S_LDR_WAIT;
            S_LDR_WAIT: begin
                if (moc)          state_d = S_LDR_WB;
                else if (timeout) state_d = S_BUS_ERR;
                else              state_d = S_LDR_WAIT;
            end
            S_STR_ADDR: state_d = S_STR_MAR;
            S_STR_MAR:  state_d = S_STR_WAIT;
            S_STR_WAIT: begin
                if (moc) begin
                    state_d      = S_MAR;
                    instr_done_d = 1'b1;
                end else if (timeout) begin
                    state_d = S_BUS_ERR;
                end else begin
                    state_d = S_STR_WAIT;
                end
            end
            default: state_d = S_RESET;
        endcase

        // Wait states are only ever entered from non-wait states, so a zero
        // outside the wait states doubles as the clear-on-entry.
        wait_cnt_d = (in_wait && !moc && !timeout) ? wait_cnt_q + 6'd1 : '0;

        und_trap_d = (state_d == S_UNDEF);
        bus_err_d  = (state_d == S_BUS_ERR);
    end

    // State, wait counter and registered pulses with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RESET;
            wait_cnt_q   <= '0;
            instr_done_q <= 1'b0;
            und_trap_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            instr_done_q <= instr_done_d;
            und_trap_q   <= und_trap_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign state      = state_q;
    assign instr_done = instr_done_q;
    assign und_trap   = und_trap_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_next_state_unit.sv
// Bench for next_state_unit: directed sequences plus randomized traffic
// against a routine-level reference model.
module tb_next_state_unit;

    localparam int unsigned TMO = 15;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic        cond_true;
    logic        moc;
    logic [6:0]  state;
    logic        instr_done;
    logic        und_trap;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    next_state_unit #(.MOC_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir),
        .cond_true  (cond_true),
        .moc        (moc),
        .state      (state),
        .instr_done (instr_done),
        .und_trap   (und_trap),
        .bus_err    (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a plan of upcoming states; entries >= 1000 are wait
    // states (value - 1000). An empty plan means the routine has ended.
    int m_plan[$];
    int m_state   = 0;
    bit m_inwait  = 1'b0;
    int m_waited  = 0;
    bit m_done    = 1'b0;
    bit m_und     = 1'b0;
    bit m_berr    = 1'b0;

    task automatic model_advance();
        int n;
        if (m_plan.size() == 0) begin
            m_state  = 1;
            m_done   = 1'b1;
            m_inwait = 1'b0;
            m_plan   = '{2, 1003, 4};
        end else begin
            n        = m_plan.pop_front();
            m_inwait = (n >= 1000);
            m_state  = n % 1000;
            m_waited = 0;
        end
    endtask

    task automatic load_routine(input logic [31:0] i);
        int op;
        op = int'(i[27:25]);
        case (op)
            1: m_plan = '{10};
            0: if (i[4]) m_plan = '{127}; else m_plan = '{11};
            5: if (i[24]) m_plan = '{21, 22}; else m_plan = '{20};
            2: if (i[20]) m_plan = '{30, 31, 1032, 33}; else m_plan = '{40, 41, 1042};
            default: m_plan = '{127};
        endcase
    endtask

    task automatic model_edge(input bit rst, input bit moc_i, input logic [31:0] ir_i, input bit c);
        m_done = 1'b0;
        m_berr = 1'b0;
        if (rst) begin
            m_state  = 0;
            m_plan.delete();
            m_inwait = 1'b0;
            m_waited = 0;
        end else if (m_inwait) begin
            if (moc_i) begin
                model_advance();
            end else begin
                m_waited++;
                if (m_waited == int'(TMO)) begin
                    m_plan.delete();
                    m_inwait = 1'b0;
                    m_state  = 126;
                    m_berr   = 1'b1;
                end
            end
        end else if (m_state == 0) begin
            m_state = 1;
            m_plan  = '{2, 1003, 4};
        end else if (m_state == 4 && c) begin
            load_routine(ir_i);
            model_advance();
        end else begin
            model_advance();
        end
        m_und = (m_state == 127);
    endtask

    task automatic step(input bit rst, input bit moc_i, input logic [31:0] ir_i, input bit c);
        reset     = rst;
        moc       = moc_i;
        ir        = ir_i;
        cond_true = c;
        @(posedge clk);
        model_edge(rst, moc_i, ir_i, c);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, $urandom, 1'b1);
        step(1'b1, 1'b0, $urandom, 1'b0);
        n_checks++;
        if (state !== 7'd0 || instr_done !== 1'b0 || und_trap !== 1'b0 || bus_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: state=%0d done=%b und=%b berr=%b required 0 0 0 0",
                     state, instr_done, und_trap, bus_err);
        end
    endtask

    task automatic test_mov();
        int exp_s[$] = '{0, 1, 2, 3, 4, 10, 1};
        for (int k = 0; k < exp_s.size(); k++) begin
            step(k == 0, k >= 3, 32'hE3A01005, 1'b1);
            n_checks++;
            if (state !== 7'(exp_s[k]) || state !== 7'(m_state) ||
                instr_done !== (k == 6) || und_trap !== 1'b0 || bus_err !== 1'b0) begin
                n_errors++;
                $display("FAIL mov[%0d]: state=%0d done=%b und=%b berr=%b required state=%0d done=%b",
                         k, state, instr_done, und_trap, bus_err, exp_s[k], k == 6);
            end
        end
    endtask

    task automatic test_ldr();
        int exp_s[$] = '{0, 1, 2, 3, 3, 3, 4, 30, 31, 32, 32, 32, 33, 1};
        bit mv;
        for (int k = 0; k < exp_s.size(); k++) begin
            mv = (k != 0) && m_inwait && (m_waited == 2);
            step(k == 0, mv, 32'hE5910000, 1'b1);
            n_checks++;
            if (state !== 7'(exp_s[k]) || state !== 7'(m_state) ||
                instr_done !== (k == 13) || bus_err !== 1'b0) begin
                n_errors++;
                $display("FAIL ldr[%0d]: state=%0d done=%b berr=%b required state=%0d done=%b",
                         k, state, instr_done, bus_err, exp_s[k], k == 13);
            end
        end
    endtask

    task automatic test_bl();
        int exp_t[$] = '{0, 1, 2, 3, 4, 21, 22, 1};
        int exp_f[$] = '{2, 3, 4, 1};
        for (int k = 0; k < exp_t.size(); k++) begin
            step(k == 0, 1'b1, 32'hEB000000, 1'b1);
            n_checks++;
            if (state !== 7'(exp_t[k]) || state !== 7'(m_state) || instr_done !== (k == 7)) begin
                n_errors++;
                $display("FAIL bl_taken[%0d]: state=%0d done=%b required state=%0d done=%b",
                         k, state, instr_done, exp_t[k], k == 7);
            end
        end
        for (int k = 0; k < exp_f.size(); k++) begin
            step(1'b0, 1'b1, 32'hEB000000, 1'b0);
            n_checks++;
            if (state !== 7'(exp_f[k]) || state !== 7'(m_state) || instr_done !== (k == 3)) begin
                n_errors++;
                $display("FAIL bl_skip[%0d]: state=%0d done=%b required state=%0d done=%b",
                         k, state, instr_done, exp_f[k], k == 3);
            end
        end
    endtask

    task automatic test_timeout();
        int exp_s[$];
        bit mv;
        exp_s = '{0, 1, 2};
        for (int k = 0; k < int'(TMO); k++) exp_s.push_back(3);
        exp_s.push_back(126);
        exp_s.push_back(1);
        for (int k = 0; k < exp_s.size(); k++) begin
            step(k == 0, 1'b0, 32'hE3A01005, 1'b1);
            n_checks++;
            if (state !== 7'(exp_s[k]) || state !== 7'(m_state) ||
                bus_err !== (exp_s[k] == 126) || instr_done !== (k == exp_s.size() - 1)) begin
                n_errors++;
                $display("FAIL timeout[%0d]: state=%0d berr=%b done=%b required state=%0d",
                         k, state, bus_err, instr_done, exp_s[k]);
            end
        end
        // moc arriving on the last allowed wait cycle wins over the timeout
        exp_s = '{0, 1, 2};
        for (int k = 0; k < int'(TMO); k++) exp_s.push_back(3);
        exp_s.push_back(4);
        for (int k = 0; k < exp_s.size(); k++) begin
            mv = (k != 0) && m_inwait && (m_waited == int'(TMO) - 1);
            step(k == 0, mv, 32'hE3A01005, 1'b1);
            n_checks++;
            if (state !== 7'(exp_s[k]) || state !== 7'(m_state) || bus_err !== 1'b0) begin
                n_errors++;
                $display("FAIL moc_priority[%0d]: state=%0d berr=%b required state=%0d berr=0",
                         k, state, bus_err, exp_s[k]);
            end
        end
    endtask

    task automatic test_undef_and_midwait_reset();
        int exp_s[$] = '{0, 1, 2, 3, 4, 127, 1};
        int budget;
        for (int k = 0; k < exp_s.size(); k++) begin
            step(k == 0, 1'b1, 32'hE7F000F0, 1'b1);
            n_checks++;
            if (state !== 7'(exp_s[k]) || state !== 7'(m_state) ||
                und_trap !== (k == 5) || instr_done !== (k == 6)) begin
                n_errors++;
                $display("FAIL undef[%0d]: state=%0d und=%b done=%b required state=%0d und=%b",
                         k, state, und_trap, instr_done, exp_s[k], k == 5);
            end
        end
        budget = 0;
        while (m_state != 32 && budget < 20) begin
            step(1'b0, m_state == 3, 32'hE5910000, 1'b1);
            budget++;
        end
        n_checks++;
        if (state !== 7'd32) begin
            n_errors++;
            $display("FAIL reach_ldr_wait: state=%0d required 32 within 20 cycles", state);
        end
        step(1'b0, 1'b0, 32'hE5910000, 1'b1);
        step(1'b1, 1'b1, 32'hE5910000, 1'b1);
        n_checks++;
        if (state !== 7'd0 || instr_done !== 1'b0 || und_trap !== 1'b0 || bus_err !== 1'b0) begin
            n_errors++;
            $display("FAIL midwait_reset: state=%0d done=%b und=%b berr=%b required 0 0 0 0",
                     state, instr_done, und_trap, bus_err);
        end
        step(1'b0, 1'b1, 32'hE5910000, 1'b1);
        n_checks++;
        if (state !== 7'd1 || instr_done !== 1'b0) begin
            n_errors++;
            $display("FAIL restart: state=%0d done=%b required state=1 done=0", state, instr_done);
        end
    endtask

    task automatic test_random();
        bit          r;
        bit          mv;
        bit          c;
        logic [31:0] iv;
        int          quiet;
        quiet = 0;
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) quiet = $urandom_range(10, 20);
            mv = (quiet > 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
            if (quiet > 0) quiet--;
            c  = $urandom_range(0, 3) != 0;
            iv = $urandom;
            step(r, mv, iv, c);
            n_checks++;
            if (state !== 7'(m_state) || instr_done !== m_done ||
                und_trap !== m_und || bus_err !== m_berr) begin
                n_errors++;
                $display("FAIL random[%0d]: state=%0d done=%b und=%b berr=%b required %0d %b %b %b",
                         k, state, instr_done, und_trap, bus_err, m_state, m_done, m_und, m_berr);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        moc       = 1'b0;
        ir        = '0;
        cond_true = 1'b0;
        test_reset();
        test_mov();
        test_ldr();
        test_bl();
        test_timeout();
        test_undef_and_midwait_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/next_state_unit.md
NEXT_STATE_UNIT -- requirements
Module: next_state_unit

Interface
REQ-001 The block SHALL have the parameter: MOC_TIMEOUT, 15, maximum wait-state cycles with moc low before a bus error (legal range 2..63).
REQ-002 The block SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-003 The block SHALL have these data ports: ir  input  32  current instruction register contents; cond_true  input  1  condition-tester result for ir[31:28]; moc  input  1  memory operation complete; state  output  7  current control-unit state number, registered; instr_done  output  1  one-cycle pulse when an instruction routine ends; und_trap  output  1  one-cycle pulse on an undefined encoding; bus_err  output  1  one-cycle pulse on a memory timeout.

Function
REQ-004 state SHALL be the block's only state register and SHALL drive the control unit's state input directly; every transition below SHALL take exactly one clk edge.
REQ-005 The fetch path SHALL be: 0 -> 1; 1 (MAR<-PC) -> 2; 2 (PC+4, read start) -> 3; 3 (wait) -> 4 when moc=1, otherwise hold 3.
REQ-006 In state 4 (decode), if cond_true=0 the next state SHALL be 1 with an instr_done pulse; if cond_true=1 the next state SHALL be the encoder start state.
REQ-007 The encoder SHALL decode as follows: ir[27:25]=001 -> 10; ir[27:25]=000 with ir[4]=0 -> 11; ir[27:25]=101 with ir[24]=0 -> 20; ir[27:25]=101 with ir[24]=1 -> 21; ir[27:25]=010 with ir[20]=1 -> 30; ir[27:25]=010 with ir[20]=0 -> 40; every other encoding -> 127.
REQ-008 The routine sequences SHALL be: 10 -> 1; 11 -> 1; 20 -> 1; 21 -> 22 -> 1; 30 -> 31 -> 32 (wait) -> 33 -> 1; 40 -> 41 -> 42 (wait) -> 1; 127 -> 1.
REQ-009 The wait states SHALL be 3, 32 and 42: hold while moc=0 and advance on the first cycle that moc=1.
REQ-010 A 6-bit wait counter SHALL clear on entry to any wait state and SHALL increment each cycle the block is in a wait state with moc=0.
REQ-011 If the block is in a wait state with moc=0 and the counter equals MOC_TIMEOUT-1, the next state SHALL be 126 and bus_err SHALL pulse for one cycle coincident with state=126; state 126 SHALL then go to 1.
REQ-012 moc=1 SHALL take priority over timeout in the same cycle: the block advances normally with no bus_err.
REQ-013 instr_done SHALL be registered and asserted for the one cycle in which state=1 after any routine exit: 10, 11, 20, 22, 33, 42, 126, 127, or 4 with cond_true=0.
REQ-014 instr_done SHALL NOT be asserted in the cycle after 0 -> 1.
REQ-015 und_trap SHALL assert for the one cycle in which state=127.
REQ-016 Any unlisted state value (5..9, 12..19, 23..29, 34..39, 43..125) SHALL go to 0 on the next edge, and no pulse output SHALL assert.
REQ-017 The moc input SHALL be ignored outside the wait states.
REQ-018 ir and cond_true SHALL be sampled only in state 4.

Reset
REQ-019 When reset=1 at a clk edge, the block SHALL set state=0, instr_done=0, und_trap=0, bus_err=0 and wait counter=0, regardless of the current state, including mid-wait.
REQ-020 Reset SHALL take priority over every other transition, and the fetch path SHALL restart 0 -> 1 on the first edge after reset deasserts.

Verification
REQ-021 Reset, then moc=1 from cycle 3, ir=0xE3A01005 (MOV imm), cond_true=1 -> states 0,1,2,3,4,10,1; instr_done high exactly at the final 1.
REQ-022 ir=0xE5910000 (LDR), moc pulsed high 2 cycles after each wait entry -> states 0,1,2,3,3,3,4,30,31,32,32,32,33,1.
REQ-023 ir=0xEB000000 (BL), cond_true=1 -> 4,21,22,1; same ir with cond_true=0 -> 4,1 with instr_done pulse.
REQ-024 moc held 0 in state 3 with MOC_TIMEOUT=15 -> 15 cycles in state 3, then 126 with bus_err=1, then 1 with instr_done=1; moc=1 on the 15th wait cycle -> state 4, no bus_err.
REQ-025 ir=0xE7F000F0 (undefined) -> 4,127 (und_trap=1),1; reset asserted while in state 32 -> state 0 next edge, all pulse outputs 0.
